// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the segment sequencer that programs WaveformGenerator.
package wave_seq_pkg;

  localparam int unsigned DUR_W = 16;

  localparam logic [1:0] WAVE_OFF    = 2'b00;
  localparam logic [1:0] WAVE_SQUARE = 2'b01;
  localparam logic [1:0] WAVE_SAW    = 2'b10;

  typedef struct packed {
    logic [1:0]       wave_def;
    logic [15:0]      freq;
    logic [9:0]       amp;
    logic [DUR_W-1:0] dur;
  } seg_t;

  localparam int unsigned SEG_W = $bits(seg_t);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  // A zero duration is played as a single tick.
  function automatic logic [DUR_W-1:0] dur_min1(input logic [DUR_W-1:0] dur);
    return (dur == '0) ? DUR_W'(1) : dur;
  endfunction

endpackage

// File: rtl/wave_seq_timer.sv
// Segment timer: TICK_DIV-cycle prescaler feeding a per-segment tick down-counter.
module wave_seq_timer
  import wave_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [DUR_W-1:0] i_dur,
  output logic             o_tick,
  output logic             o_seg_end
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PreMax = PW'(TICK_DIV - 1);

  logic [PW-1:0]    r_pre;
  logic [DUR_W-1:0] r_dur;

  assign o_tick = i_run && (r_pre == PreMax);
  // Final tick of the segment is pending; only meaningful together with o_tick.
  assign o_seg_end = (r_dur == DUR_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre <= '0;
      r_dur <= '0;
    end else if (i_clear) begin
      r_pre <= '0;
      r_dur <= '0;
    end else if (i_load) begin
      r_pre <= '0;
      r_dur <= dur_min1(i_dur);
    end else if (o_tick) begin
      r_pre <= '0;
      r_dur <= r_dur - 1'b1;
    end else if (i_run) begin
      r_pre <= r_pre + 1'b1;
    end
  end

endmodule

// File: rtl/wave_sequencer.sv
// Plays a table of {wave_def, freq, amp, dur} segments into WaveformGenerator, optionally looping.
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter int unsigned NUM_SEG  = 8,
  parameter int unsigned TICK_DIV = 10,
  localparam int unsigned AW      = $clog2(NUM_SEG)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_we,
  input  logic [AW-1:0]    i_cfg_addr,
  input  logic [SEG_W-1:0] i_cfg_data,
  input  logic [AW-1:0]    i_last_seg,
  input  logic             i_loop_en,
  input  logic             i_start,
  input  logic             i_stop,
  output logic [1:0]       o_wave_def,
  output logic [15:0]      o_freq,
  output logic [9:0]       o_amp,
  output logic [AW-1:0]    o_seg_idx,
  output logic             o_seg_strobe,
  output logic             o_busy,
  output logic             o_done
);

  seg_t          r_tab [NUM_SEG];
  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_last;
  logic [1:0]    r_wave;
  logic [15:0]   r_freq;
  logic [9:0]    r_amp;
  logic          r_strobe;
  logic          r_busy;
  logic          r_done;

  logic          w_tick;
  logic          w_final;
  logic          w_seg_end;
  logic          w_is_last;
  logic          w_load;
  logic [AW-1:0] w_next_idx;
  seg_t          w_entry;

  // Table is deliberately not reset; a same-cycle write is seen only by later loads.
  always_ff @(posedge i_clk) begin
    if (i_cfg_we) begin
      r_tab[i_cfg_addr] <= seg_t'(i_cfg_data);
    end
  end

  always_comb begin
    w_is_last  = (r_idx == r_last);
    w_next_idx = ((r_state == LOAD) || w_is_last) ? '0 : r_idx + 1'b1;
    w_entry    = r_tab[w_next_idx];
    w_seg_end  = (r_state == RUN) && w_tick && w_final;
    w_load     = !i_stop &&
                 ((r_state == LOAD) || (w_seg_end && !(w_is_last && !i_loop_en)));
  end

  wave_seq_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (i_stop || (r_state == IDLE)),
    .i_load    (w_load),
    .i_run     (r_state == RUN),
    .i_dur     (w_entry.dur),
    .o_tick    (w_tick),
    .o_seg_end (w_final)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_last   <= '0;
      r_wave   <= WAVE_OFF;
      r_freq   <= '0;
      r_amp    <= '0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      if (w_load) begin
        r_state  <= RUN;
        r_idx    <= w_next_idx;
        r_wave   <= w_entry.wave_def;
        r_freq   <= w_entry.freq;
        r_amp    <= w_entry.amp;
        r_strobe <= 1'b1;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (i_start && !i_stop) begin
              r_state <= LOAD;
              r_last  <= i_last_seg;
              r_busy  <= 1'b1;
            end
          end
          LOAD, RUN: begin
            // Without a load here, only a stop or the final segment end can apply.
            if (i_stop || w_seg_end) begin
              r_state <= IDLE;
              r_idx   <= '0;
              r_wave  <= WAVE_OFF;
              r_freq  <= '0;
              r_amp   <= '0;
              r_busy  <= 1'b0;
              r_done  <= !i_stop;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_wave_def   = r_wave;
  assign o_freq       = r_freq;
  assign o_amp        = r_amp;
  assign o_seg_idx    = r_idx;
  assign o_seg_strobe = r_strobe;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: timing vectors, corner sequences, random run vs model.
module tb_wave_sequencer;
  import wave_seq_pkg::*;

  localparam int unsigned NUM_SEG  = 8;
  localparam int unsigned TICK_DIV = 10;
  localparam int unsigned AW       = 3;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             cfg_we   = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [SEG_W-1:0] cfg_data = '0;
  logic [AW-1:0]    last_seg = '0;
  logic             loop_en  = 1'b0;
  logic             start    = 1'b0;
  logic             stop     = 1'b0;
  logic [1:0]       wave_def;
  logic [15:0]      freq;
  logic [9:0]       amp;
  logic [AW-1:0]    seg_idx;
  logic             seg_strobe;
  logic             busy;
  logic             done;

  wave_sequencer #(
    .NUM_SEG  (NUM_SEG),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_we     (cfg_we),
    .i_cfg_addr   (cfg_addr),
    .i_cfg_data   (cfg_data),
    .i_last_seg   (last_seg),
    .i_loop_en    (loop_en),
    .i_start      (start),
    .i_stop       (stop),
    .o_wave_def   (wave_def),
    .o_freq       (freq),
    .o_amp        (amp),
    .o_seg_idx    (seg_idx),
    .o_seg_strobe (seg_strobe),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #50 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int nprint = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: each segment is a block of max(dur,1)*TICK_DIV clocks.
  seg_t        m_tab [NUM_SEG];
  int          m_phase = 0;  // 0 idle, 1 start accepted, 2 playing
  int          m_idx   = 0;
  int          m_last  = 0;
  int          m_rem   = 0;
  logic [1:0]  m_wave  = '0;
  logic [15:0] m_freq  = '0;
  logic [9:0]  m_amp   = '0;
  logic        m_strobe = 1'b0;
  logic        m_done   = 1'b0;

  task automatic m_play(input int i);
    m_idx    = i;
    m_wave   = m_tab[i].wave_def;
    m_freq   = m_tab[i].freq;
    m_amp    = m_tab[i].amp;
    m_rem    = ((m_tab[i].dur == 0) ? 1 : int'(m_tab[i].dur)) * TICK_DIV;
    m_strobe = 1'b1;
  endtask

  task automatic m_zero();
    m_phase = 0;
    m_idx   = 0;
    m_wave  = '0;
    m_freq  = '0;
    m_amp   = '0;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_zero();
      m_strobe = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_strobe = 1'b0;
      m_done   = 1'b0;
      if (m_phase == 0) begin
        if (start && !stop) begin
          m_phase = 1;
          m_last  = int'(last_seg);
        end
      end else if (stop) begin
        m_zero();
      end else if (m_phase == 1) begin
        m_phase = 2;
        m_play(0);
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_idx != m_last)  m_play(m_idx + 1);
          else if (loop_en)     m_play(0);
          else begin
            m_zero();
            m_done = 1'b1;
          end
        end
      end
      if (cfg_we) m_tab[cfg_addr] = seg_t'(cfg_data);
    end
  end

  initial forever begin
    @(negedge clk);
    checks++;
    if ({wave_def, freq, amp, seg_idx, seg_strobe, busy, done} !==
        {m_wave, m_freq, m_amp, AW'(m_idx), m_strobe, (m_phase != 0), m_done}) begin
      errors++;
      if (nprint < 20) begin
        nprint++;
        $display("FAIL model cyc=%0d got w=%0d f=%0d a=%0d i=%0d s=%b b=%b d=%b exp w=%0d f=%0d a=%0d i=%0d s=%b b=%b d=%b",
                 cyc, wave_def, freq, amp, seg_idx, seg_strobe, busy, done,
                 m_wave, m_freq, m_amp, m_idx, m_strobe, (m_phase != 0), m_done);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [1:0] w, input int f, input int am, input int d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_data = {w, 16'(f), 10'(am), DUR_W'(d)};
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Leaves the caller at the negedge of cycle n+1.
  task automatic pulse_start(output int n);
    @(negedge clk);
    start = 1'b1;
    n     = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_done(input int bound, output int t);
    t = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done) begin
        t = cyc;
        return;
      end
    end
  endtask

  typedef struct {
    int d0;
    int d1;
    int last;
    int exp_t1;
    int exp_td;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #6000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d expected < 60000", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    int t1;
    int td;
    int dn;

    vecs[0] = '{100, 150, 1, 1002, 2502};
    vecs[1] = '{0, 3, 1, 12, 42};
    vecs[2] = '{5, 7, 0, -1, 52};
    vecs[3] = '{1, 0, 1, 12, 22};

    // Reset
    repeat (3) @(negedge clk);
    check("reset_amp", int'(amp), 0);
    check("reset_freq", int'(freq), 0);
    check("reset_wave", int'(wave_def), 0);
    check("reset_idx", int'(seg_idx), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_strobe", int'(seg_strobe), 0);
    rst_n = 1'b1;
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("reset_quiet", dn, 0);

    // Timing vectors
    foreach (vecs[v]) begin
      wr(0, WAVE_SQUARE, 20000, 256, vecs[v].d0);
      wr(1, WAVE_SAW, 10000, 1023, vecs[v].d1);
      last_seg = AW'(vecs[v].last);
      loop_en  = 1'b0;
      pulse_start(n);
      t1 = -1;
      td = -1;
      for (int k = 0; k < 4000; k++) begin
        @(negedge clk);
        if (seg_strobe && seg_idx == AW'(1) && t1 < 0) t1 = cyc - n;
        if (done) begin
          td = cyc - n;
          check($sformatf("vec%0d_done_amp", v), int'(amp), 0);
          check($sformatf("vec%0d_done_busy", v), int'(busy), 0);
          break;
        end
      end
      check($sformatf("vec%0d_seg1_at", v), t1, vecs[v].exp_t1);
      check($sformatf("vec%0d_done_at", v), td, vecs[v].exp_td);
    end

    // Loop, then drop loop_en in the second pass
    wr(0, WAVE_SQUARE, 20000, 256, 100);
    wr(1, WAVE_SAW, 10000, 1023, 150);
    last_seg = AW'(1);
    loop_en  = 1'b1;
    pulse_start(n);
    wait_until(n + 2502);
    check("loop_strobe", int'(seg_strobe), 1);
    check("loop_idx", int'(seg_idx), 0);
    check("loop_freq", int'(freq), 20000);
    check("loop_nodone", int'(done), 0);
    loop_en = 1'b0;
    wait_done(3000, t);
    check("loop_done_at", t - n, 5002);

    // Stop mid-segment
    pulse_start(n);
    wait_until(n + 500);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_amp", int'(amp), 0);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("stop_nodone", dn, 0);

    // Start and stop together from IDLE
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy0", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("startstop_busy1", int'(busy), 0);

    // Rewrite seg1 during seg0, and a start while busy
    wr(0, WAVE_SQUARE, 1000, 100, 2);
    wr(1, WAVE_SAW, 2000, 200, 4);
    last_seg = AW'(1);
    pulse_start(n);
    wait_until(n + 5);
    cfg_we   = 1'b1;
    cfg_addr = AW'(1);
    cfg_data = {WAVE_SQUARE, 16'd5000, 10'd512, DUR_W'(3)};
    @(negedge clk);
    cfg_we = 1'b0;
    wait_until(n + 7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(n + 22);
    check("rewr_strobe", int'(seg_strobe), 1);
    check("rewr_idx", int'(seg_idx), 1);
    check("rewr_freq", int'(freq), 5000);
    check("rewr_amp", int'(amp), 512);
    check("rewr_wave", int'(wave_def), int'(WAVE_SQUARE));
    wait_done(100, t);
    check("rewr_done_at", t - n, 52);

    // Asynchronous reset mid-seg1
    wr(0, WAVE_SQUARE, 3000, 300, 3);
    wr(1, WAVE_SAW, 4000, 400, 5);
    pulse_start(n);
    wait_until(n + 35);
    check("arst_pre_amp", int'(amp), 400);
    #10;
    rst_n = 1'b0;
    #1;
    check("arst_amp", int'(amp), 0);
    check("arst_freq", int'(freq), 0);
    check("arst_wave", int'(wave_def), 0);
    check("arst_idx", int'(seg_idx), 0);
    check("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(n);
    @(negedge clk);
    check("arst_restart_strobe", int'(seg_strobe), 1);
    check("arst_restart_idx", int'(seg_idx), 0);
    check("arst_restart_amp", int'(amp), 300);

    // Randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      for (int a = 0; a < int'(NUM_SEG); a++) begin
        wr(a, 2'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 1023)), int'($urandom_range(0, 4)));
      end
      last_seg = AW'($urandom_range(0, NUM_SEG - 1));
      loop_en  = 1'($urandom_range(0, 1));
      repeat (100) begin
        @(negedge clk);
        start    = ($urandom_range(0, 9) == 0);
        stop     = ($urandom_range(0, 39) == 0);
        cfg_we   = ($urandom_range(0, 7) == 0);
        cfg_addr = AW'($urandom_range(0, NUM_SEG - 1));
        cfg_data = {2'($urandom_range(0, 3)), 16'($urandom), 10'($urandom), DUR_W'($urandom_range(0, 3))};
        if ($urandom_range(0, 19) == 0) loop_en = ~loop_en;
        if ($urandom_range(0, 19) == 0) last_seg = AW'($urandom_range(0, NUM_SEG - 1));
      end
      @(negedge clk);
      start  = 1'b0;
      stop   = 1'b0;
      cfg_we = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
